// File: rtl/ofs_plat_prim_ram_read_stream.sv
`default_nettype none
// ============================================================================
// Module   : ofs_plat_prim_ram_read_stream
// Brief    : Streams reads from a fixed-latency simple dual-port RAM into a
//            credit-protected response FIFO with ready/valid handshakes.
//            Optional address-range check: OFS_PLAT_RAM_READ_STREAM_ADDR_CHECK_EN
// Revision : 1.0 - initial release
// ============================================================================
module ofs_plat_prim_ram_read_stream #(
  parameter int N_ENTRIES    = 32,
  parameter int N_DATA_BITS  = 64,
  parameter int READ_LATENCY = 1,
  parameter int N_OUT_BUF    = READ_LATENCY + 2
) (
  input  logic                           clk,
  input  logic                           reset,

  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [$clog2(N_ENTRIES)-1:0]   req_addr,

  output logic [$clog2(N_ENTRIES)-1:0]   ram_raddr,
  input  logic [N_DATA_BITS-1:0]         ram_rdata,

  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [N_DATA_BITS-1:0]         rsp_data,

  output logic                           err_addr
);

  localparam int c_addr_w = $clog2(N_ENTRIES);
  localparam int c_cnt_w  = $clog2(N_OUT_BUF + 1);
  localparam int c_ptr_w  = (N_OUT_BUF > 1) ? $clog2(N_OUT_BUF) : 1;

  localparam logic [c_cnt_w-1:0] c_credits_full = c_cnt_w'(N_OUT_BUF);
  localparam logic [c_cnt_w-1:0] c_cnt_one      = c_cnt_w'(1);
  localparam logic [c_ptr_w-1:0] c_ptr_last     = c_ptr_w'(N_OUT_BUF - 1);
  localparam logic [c_ptr_w-1:0] c_ptr_one      = c_ptr_w'(1);

  logic [c_cnt_w-1:0]      r_credits;
  logic [c_cnt_w-1:0]      r_count;
  logic [c_ptr_w-1:0]      r_wr_ptr;
  logic [c_ptr_w-1:0]      r_rd_ptr;
  logic [READ_LATENCY-1:0] r_pipe;
  logic [N_DATA_BITS-1:0]  r_fifo [N_OUT_BUF];

  logic w_accept;
  logic w_push;
  logic w_pop;

  // The RAM sees the request address directly so the read starts in the
  // acceptance cycle.
  assign ram_raddr = req_addr;

  // Ready depends only on the credit register (and reset), never on rsp_ready.
  assign req_ready = (r_credits != '0) && !reset;
  assign w_accept  = req_valid && req_ready;

  assign rsp_valid = (r_count != '0) && !reset;
  assign rsp_data  = r_fifo[r_rd_ptr];
  assign w_pop     = rsp_valid && rsp_ready;

  assign w_push    = r_pipe[READ_LATENCY-1];

  // Valid shift pipeline tracking reads in flight inside the RAM
  generate
    if (READ_LATENCY == 1) begin : g_pipe_single
      always_ff @(posedge clk) begin
        if (reset) begin
          r_pipe <= '0;
        end else begin
          r_pipe[0] <= w_accept;
        end
      end
    end else begin : g_pipe_shift
      always_ff @(posedge clk) begin
        if (reset) begin
          r_pipe <= '0;
        end else begin
          r_pipe <= {r_pipe[READ_LATENCY-2:0], w_accept};
        end
      end
    end
  endgenerate

  // Credits reserve a FIFO slot at acceptance, so the FIFO cannot overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_credits <= c_credits_full;
    end else begin
      case ({w_accept, w_pop})
        2'b10:   r_credits <= r_credits - c_cnt_one;
        2'b01:   r_credits <= r_credits + c_cnt_one;
        default: r_credits <= r_credits;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == c_ptr_last) ? '0 : r_wr_ptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == c_ptr_last) ? '0 : r_rd_ptr + c_ptr_one;
      end
    end
  end

  // Storage needs no reset; occupancy is tracked by r_count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= ram_rdata;
    end
  end

`ifdef OFS_PLAT_RAM_READ_STREAM_ADDR_CHECK_EN
  localparam logic [c_addr_w:0] c_addr_limit = (c_addr_w + 1)'(N_ENTRIES);

  logic r_err_addr;

  // Sticky until reset; the offending request is still serviced.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err_addr <= 1'b0;
    end else if (w_accept && ({1'b0, req_addr} >= c_addr_limit)) begin
      r_err_addr <= 1'b1;
    end
  end

  assign err_addr = r_err_addr && !reset;
`else
  assign err_addr = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/ofs_plat_prim_ram_read_stream.md
OFS_PLAT_PRIM_RAM_READ_STREAM -- requirements
Module: ofs_plat_prim_ram_read_stream

Interface
REQ-001 Parameter N_ENTRIES, default 32: depth of the attached simple dual-port RAM.
REQ-002 Parameter N_DATA_BITS, default 64: RAM and response data width.
REQ-003 Parameter READ_LATENCY, default 1: cycles from ram_raddr to valid ram_rdata; legal range 1..4.
REQ-004 Parameter N_OUT_BUF, default READ_LATENCY+2: response buffer depth; legal range 1..16.
REQ-005 clk  input  1  single clock for all logic; the attached RAM's read clock is driven from the same clock.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 req_valid  input  1  read request present.
REQ-008 req_ready  output  1  request accepted when req_valid && req_ready.
REQ-009 req_addr  input  $clog2(N_ENTRIES)  read address.
REQ-010 ram_raddr  output  $clog2(N_ENTRIES)  RAM read address.
REQ-011 ram_rdata  input  N_DATA_BITS  RAM read data, valid READ_LATENCY cycles after ram_raddr.
REQ-012 rsp_valid  output  1  response data present.
REQ-013 rsp_ready  input  1  response consumed when rsp_valid && rsp_ready.
REQ-014 rsp_data  output  N_DATA_BITS  response data.
REQ-015 err_addr  output  1  sticky out-of-range-address flag (see Configuration).

Function
REQ-016 ram_raddr SHALL equal req_addr combinationally; a request issues to the RAM in its acceptance cycle.
REQ-017 An accepted request SHALL enter a READ_LATENCY-deep valid shift pipeline; on exit, ram_rdata SHALL be written to the response FIFO in that cycle.
REQ-018 Responses SHALL be returned in request order, one per accepted request; none dropped, none duplicated.
REQ-019 Credit counter, width $clog2(N_OUT_BUF+1), reset value N_OUT_BUF: decrement on request accept, increment on response pop, unchanged when both occur in the same cycle.
REQ-020 req_ready SHALL be (credits != 0) && !reset, derived from registered state only, with no combinational path from rsp_ready.
REQ-021 In-flight plus buffered entries SHALL never exceed N_OUT_BUF; the FIFO SHALL never overflow.
REQ-022 Latency: a request accepted in cycle t into an empty block SHALL yield rsp_valid=1 in cycle t+READ_LATENCY+1.
REQ-023 rsp_valid and rsp_data SHALL stay stable while rsp_valid && !rsp_ready.
REQ-024 Throughput: with N_OUT_BUF >= READ_LATENCY+2 and rsp_ready held high, the block SHALL sustain one request and one response per cycle.
REQ-025 Full boundary: at credits==0, req_ready=0 until a pop; it returns to 1 on the cycle after the pop.
REQ-026 Empty boundary: with the FIFO empty, rsp_valid=0; a FIFO write and a pop in the same cycle are both legal.
REQ-027 FIFO read and write pointers SHALL wrap modulo N_OUT_BUF.

Reset
REQ-028 During reset, outputs SHALL be: req_ready=0, rsp_valid=0, err_addr=0.
REQ-029 Reset SHALL clear the valid pipeline and the FIFO, and set credits=N_OUT_BUF; requests in flight when reset asserts mid-operation are discarded, and no response for them appears after reset.
REQ-030 req_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-031 Macro OFS_PLAT_RAM_READ_STREAM_ADDR_CHECK_EN.
REQ-032 Macro defined: an accepted req_addr >= N_ENTRIES SHALL set err_addr on the next cycle, and err_addr stays set until reset; the request is still serviced normally.
REQ-033 Macro undefined: err_addr SHALL be tied to 0 and no check logic is built.

Verification
REQ-034 READ_LATENCY=2, N_OUT_BUF=4, RAM preloaded with mem[i]=i*16, rsp_ready=1; request addr 5 in cycle 10 -> rsp_valid in cycle 13 with rsp_data=0x50.
REQ-035 Same config; back-to-back requests addr 0..7, rsp_ready=1 -> req_ready stays 1 throughout; responses 0x00..0x70 arrive on 8 consecutive cycles, in order.
REQ-036 rsp_ready=0; 5 requests offered -> exactly 4 accepted, then req_ready=0; raise rsp_ready -> the first pop restores req_ready on the next cycle, and the 5th request then completes.
REQ-037 Reset asserted 1 cycle after 2 requests accepted -> no rsp_valid after reset; req_ready=1 on the first post-reset cycle.
REQ-038 N_ENTRIES=24 with macro defined; request addr 30 -> err_addr=1 on the next cycle and held until reset; with macro undefined, err_addr stays 0.
REQ-039 Random valid/ready toggling, 10k requests -> data matches a scoreboard model in order; credits never exceed N_OUT_BUF and never underflow.
